// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel,
// branch redirect input and the decode-side instruction buffer handshake.
// master = fetch unit, slave = memory/decode/branch environment.
interface fetch_if #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int OPLEN = 7
);
    logic             imem_req;
    logic [XLEN-1:0]  imem_addr;
    logic             imem_gnt;
    logic             imem_rvalid;
    logic [ILEN-1:0]  imem_rdata;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic             if_valid;
    logic             if_ready;
    logic [ILEN-1:0]  if_instr;
    logic [XLEN-1:0]  if_pc;
    logic [OPLEN-1:0] if_op;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output if_valid, if_instr, if_pc, if_op,
        input  if_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  if_valid, if_instr, if_pc, if_op,
        output if_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one imem request in
// flight, buffers one returned instruction for decode and squashes the
// wrong path on a resolved taken branch.
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetched/perf_flushed.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              OPLEN    = 7,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst,
    fetch_if.master     bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    // FETCH: may request; WAIT: response will be kept; DROP: response is stale
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] r_if_pc;
    logic [ILEN-1:0] r_if_instr;
    logic            r_if_valid;

    logic            w_req;
    logic            w_fire;
    logic            w_xfer;
    logic            w_load;
    logic            w_drop;
    logic [XLEN-1:0] w_redir_pc;

    // Request only with no outstanding fetch and a buffer slot that is
    // free or being drained this cycle, so a response always has room.
    assign w_req      = (r_state == FETCH) && !bus.redirect && (!r_if_valid || bus.if_ready);
    assign w_fire     = w_req && bus.imem_gnt;
    assign w_xfer     = r_if_valid && bus.if_ready;
    assign w_load     = (r_state == WAIT) && bus.imem_rvalid && !bus.redirect;
    assign w_drop     = bus.imem_rvalid && ((r_state == DROP) || ((r_state == WAIT) && bus.redirect));
    assign w_redir_pc = bus.redirect_pc & ~XLEN'(3);

    // Next-state logic; redirect turns a pending WAIT into DROP
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            FETCH: if (w_fire) w_state_nxt = WAIT;
            WAIT: begin
                if (bus.imem_rvalid)  w_state_nxt = FETCH;
                else if (bus.redirect) w_state_nxt = DROP;
            end
            DROP:  if (bus.imem_rvalid) w_state_nxt = FETCH;
            default: w_state_nxt = FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FETCH;
        else     r_state <= w_state_nxt;
    end

    // Program counter: redirect wins over sequential advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               r_fetch_pc <= RESET_PC;
        else if (bus.redirect) r_fetch_pc <= w_redir_pc;
        else if (w_fire)       r_fetch_pc <= r_fetch_pc + XLEN'(4);
    end

    // PC of the request in flight, paired with its response
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_req_pc <= '0;
        else if (w_fire) r_req_pc <= r_fetch_pc;
    end

    // Instruction buffer valid: redirect clears, load sets, transfer clears
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               r_if_valid <= 1'b0;
        else if (bus.redirect) r_if_valid <= 1'b0;
        else if (w_load)       r_if_valid <= 1'b1;
        else if (w_xfer)       r_if_valid <= 1'b0;
    end

    // Instruction buffer payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_instr <= '0;
            r_if_pc    <= '0;
        end else if (w_load) begin
            r_if_instr <= bus.imem_rdata;
            r_if_pc    <= r_req_pc;
        end
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_fetch_pc;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_instr  = r_if_instr;
    assign bus.if_pc     = r_if_pc;
    assign bus.if_op     = r_if_instr[OPLEN-1:0];

    // A kept response must never land on an occupied buffer
    a_no_overwrite: assert property (@(posedge clk) disable iff (rst) w_load |-> !r_if_valid);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushed;
    logic        w_flush_buf;

    // A buffered instruction handed to decode in the redirect cycle counts
    // as fetched, not flushed
    assign w_flush_buf = bus.redirect && r_if_valid && !bus.if_ready;

    // Free-running event counters, wrap at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
        end else begin
            r_perf_fetched <= r_perf_fetched + 32'(w_xfer);
            r_perf_flushed <= r_perf_flushed + 32'(w_drop) + 32'(w_flush_buf);
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushed = r_perf_flushed;
`endif

endmodule
